montgomery_constant_server: RTL and testbench
=============================================

# montgomery_constant_server

Streams one precomputed Montgomery constant (k = −N⁻¹ mod R, or the modulus N / N²) block by block to a reduction or multiplication datapath.

- The consumer acknowledges each block with a one-cycle consume pulse.
- The server presents the next block least-significant first and wraps back to block 0 after the last block.
- It is the serving end of the `consumed_k_out` / `consumed_N_out` handshake. One instance is built per constant.
- The constant is loaded once through a serial write port. A 4-deep prefetch FIFO hides the 2-cycle memory latency.

## Interface
Parameters:
- `REGISTER_SIZE`, 32, width of one block in bits.
- `NUM_BLOCKS`, 128, blocks per constant (R/REGISTER_SIZE, with R = 4096).

Ports:
- `clk_in`  in  1  the single clock.
- `rst_in`  in  1  reset, asynchronous, active-high.
- `load_start_in`  in  1  pulse: flush everything and enter LOAD.
- `load_valid_in`  in  1  `load_block_in` is valid this cycle.
- `load_block_in`  in  REGISTER_SIZE  constant block, index 0 (LSB) first.
- `load_ready_out`  out  1  high while in LOAD.
- `rewind_in`  in  1  pulse: restart serving at block 0.
- `consumed_in`  in  1  consumer has taken `block_out`; advance to the next block.
- `block_out`  out  REGISTER_SIZE  current constant block.
- `block_valid_out`  out  1  `block_out` holds a real block.
- `last_block_out`  out  1  `block_out` is index NUM_BLOCKS−1.
- `underflow_out`  out  1  sticky error: `consumed_in` arrived while `block_valid_out` was 0.

## Operation
States:
- LOAD
  - `load_ready_out` = 1.
  - Each `load_valid_in` writes memory at the write index, then increments the index.
  - When block NUM_BLOCKS−1 is accepted, go to SERVE. The write index returns to 0.
- SERVE
  - The read-issue index starts at 0.
  - A read is issued whenever (FIFO occupancy + reads in flight) < 4. The issue index then increments, wrapping NUM_BLOCKS−1 → 0.
  - Returning data is pushed into the FIFO tagged with a last flag (index == NUM_BLOCKS−1).
  - `block_out`, `last_block_out` and `block_valid_out` come from the FIFO head. `block_valid_out` = FIFO non-empty.
  - `consumed_in` with `block_valid_out` = 1 pops the head.
  - `consumed_in` with `block_valid_out` = 0: no pop, no index change, `underflow_out` ← 1.
  - `load_valid_in` is ignored.
- Rewind (SERVE only)
  - Flush the FIFO.
  - Discard in-flight reads. Returns are dropped using a generation bit.
  - Set the issue index to 0.
  - `rewind_in` is ignored in LOAD.
- `load_start_in` (any state)
  - Flush the FIFO and drop in-flight reads.
  - Zero both indices and clear `underflow_out`.
  - Enter LOAD. Memory contents are retained until overwritten.

Priority for events in the same cycle: `rst_in` > `load_start_in` > `rewind_in` > `consumed_in`. A `consumed_in` in the same cycle as a rewind or load_start is discarded.

## Timing
Reset values:
- State = LOAD, `load_ready_out` = 1.
- `block_out` = 0, `block_valid_out` = 0, `last_block_out` = 0, `underflow_out` = 0.
- Indices = 0, FIFO empty.

Latency and throughput:
- Memory read latency is exactly 2 cycles (issue at X, data at X+2). Data is pushed into the FIFO at the end of X+2 and is visible at X+3.
- If the last load block is accepted in cycle L: SERVE starts in L+1, the first read is issued in L+1, and `block_valid_out` = 1 with block 0 in L+4.
- After `rewind_in` or `load_start_in` in cycle W: `block_valid_out` = 0 from W+1.
  - After a rewind, block 0 is valid at W+4.
- Steady state: consume every cycle is sustained indefinitely with no bubble, including across the NUM_BLOCKS−1 → 0 wrap.
- A pop in cycle C makes the next block visible at C+1. The FIFO must never overflow, given the issue rule above.

Reset mid-operation: all state returns to reset values immediately. Memory contents are don't-care and a reload is required.

## Structure
- Shared package `montgomery_pkg`:
  - block index width = $clog2(NUM_BLOCKS).
  - state enum {LOAD, SERVE}.
  - memory-latency constant = 2.
  - prefetch depth constant = 4.
- Sub-module `constant_prefetch_fifo`, a 4-entry FIFO with data+last per entry, push/pop/flush, and an occupancy output.
- Memory: the team's existing simple dual-port BRAM primitive, with registered output and 2-cycle latency.

## Test plan
- Load blocks i+1 (i = 0..127), then hold `consumed_in` = 1 for 300 cycles → `block_out` sequence 1..128, 1..128, 1..44 with no gaps. `last_block_out` is high exactly when `block_out` = 128. `block_valid_out` first rises 3 cycles after SERVE entry (L+4).
- Same load, random consume gaps (10–60 % duty) → identical value order, no duplicates or skips.
- Consume 10 blocks, pulse `rewind_in` at W → `block_valid_out` = 0 at W+1, `block_out` = 1 valid at W+4. Also pulse `consumed_in` with the rewind → it is ignored.
- `consumed_in` while `block_valid_out` = 0 (just after load) → `underflow_out` = 1 and stays 1, first served block is still 1. `load_start_in` clears it.
- Assert `rst_in` asynchronously mid-SERVE (between clock edges) → all outputs 0 immediately, `load_ready_out` = 1. Reload with 0xA5A5_0000+i → that stream is served.
- `load_start_in` mid-SERVE with in-flight reads, then load new values 1000+i → the first served block is 1000, with no stale old-generation blocks.

Source files
------------

// File: rtl/montgomery_pkg.sv
// Shared types and constants for the Montgomery constant server.
package montgomery_pkg;

   localparam int unsigned MEM_LATENCY    = 2;
   localparam int unsigned PREFETCH_DEPTH = 4;
   localparam int unsigned OCC_W          = $clog2(PREFETCH_DEPTH + 1);

   typedef enum logic {
      ST_LOAD  = 1'b0,
      ST_SERVE = 1'b1
   } state_t;

   // Block index width; at least one bit even for a single-block constant.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/constant_prefetch_fifo.sv
// Small prefetch FIFO holding constant blocks plus their last-block flag.
module constant_prefetch_fifo
   import montgomery_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             push_last,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head_data,
   output logic             head_last,
   output logic [OCC_W-1:0] occupancy
);

   localparam int unsigned PTR_W = $clog2(PREFETCH_DEPTH);

   logic [WIDTH-1:0] data_q [PREFETCH_DEPTH];
   logic             last_q [PREFETCH_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [OCC_W-1:0] count;

   assign head_data = data_q[rd_ptr];
   assign head_last = last_q[rd_ptr];
   assign occupancy = count;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < int'(PREFETCH_DEPTH); i++) begin
            data_q[i] <= '0;
            last_q[i] <= 1'b0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            data_q[wr_ptr] <= push_data;
            last_q[wr_ptr] <= push_last;
            wr_ptr         <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + OCC_W'(1);
            2'b01:   count <= count - OCC_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/montgomery_bram_sdp.sv
// Simple dual-port block RAM: one write port, one read port, 2-cycle registered read.
module montgomery_bram_sdp #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 128,
   parameter int unsigned AW    = 7
) (
   input  logic             clk_in,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] stage_q;

   always_ff @(posedge clk_in) begin
      if (we) mem[waddr] <= wdata;
      if (re) stage_q <= mem[raddr];
      rdata <= stage_q;
   end

endmodule

// File: rtl/montgomery_constant_server.sv
// Serves one stored Montgomery constant block by block, prefetching from BRAM
// so that a consumer can take one block per cycle across the index wrap.
module montgomery_constant_server
   import montgomery_pkg::*;
#(
   parameter int unsigned REGISTER_SIZE = 32,
   parameter int unsigned NUM_BLOCKS    = 128
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     load_start_in,
   input  logic                     load_valid_in,
   input  logic [REGISTER_SIZE-1:0] load_block_in,
   output logic                     load_ready_out,
   input  logic                     rewind_in,
   input  logic                     consumed_in,
   output logic [REGISTER_SIZE-1:0] block_out,
   output logic                     block_valid_out,
   output logic                     last_block_out,
   output logic                     underflow_out
);

   localparam int unsigned IDX_W = idx_width(NUM_BLOCKS);
   localparam int unsigned LAT   = MEM_LATENCY;
   localparam int unsigned SUM_W = OCC_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

   state_t             state, state_d;
   logic [IDX_W-1:0]   wr_idx, wr_idx_d;
   logic [IDX_W-1:0]   rd_idx, rd_idx_d;
   logic               gen, gen_d;
   logic               underflow_d;
   logic               flush, issue, pop, mem_we;
   logic [LAT-1:0]     pipe_vld, pipe_gen, pipe_last;
   logic [OCC_W-1:0]   inflight, occupancy;
   logic               room, ret_push;
   logic [REGISTER_SIZE-1:0] mem_rdata, head_data;
   logic               head_last, fifo_valid;

   // Reads from a previous generation are still in the pipe but no longer count.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < int'(LAT); i++) begin
         if (pipe_vld[i] && (pipe_gen[i] == gen)) inflight = inflight + OCC_W'(1);
      end
   end

   assign room       = (SUM_W'(occupancy) + SUM_W'(inflight)) < SUM_W'(PREFETCH_DEPTH);
   assign fifo_valid = (occupancy != '0);
   assign ret_push   = pipe_vld[LAT-1] && (pipe_gen[LAT-1] == gen) && !flush;

   always_comb begin
      state_d     = state;
      wr_idx_d    = wr_idx;
      rd_idx_d    = rd_idx;
      gen_d       = gen;
      underflow_d = underflow_out;
      flush       = 1'b0;
      issue       = 1'b0;
      pop         = 1'b0;
      mem_we      = 1'b0;
      if (load_start_in) begin
         flush       = 1'b1;
         gen_d       = ~gen;
         wr_idx_d    = '0;
         rd_idx_d    = '0;
         underflow_d = 1'b0;
         state_d     = ST_LOAD;
      end else begin
         case (state)
            ST_LOAD: begin
               if (load_valid_in) begin
                  mem_we = 1'b1;
                  if (wr_idx == LAST_IDX) begin
                     wr_idx_d = '0;
                     rd_idx_d = '0;
                     state_d  = ST_SERVE;
                  end else begin
                     wr_idx_d = wr_idx + IDX_W'(1);
                  end
               end
            end
            ST_SERVE: begin
               if (rewind_in) begin
                  flush    = 1'b1;
                  gen_d    = ~gen;
                  rd_idx_d = '0;
               end else begin
                  if (consumed_in) begin
                     if (fifo_valid) pop = 1'b1;
                     else            underflow_d = 1'b1;
                  end
                  if (room) begin
                     issue    = 1'b1;
                     rd_idx_d = (rd_idx == LAST_IDX) ? '0 : rd_idx + IDX_W'(1);
                  end
               end
            end
            default: state_d = ST_LOAD;
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state         <= ST_LOAD;
         wr_idx        <= '0;
         rd_idx        <= '0;
         gen           <= 1'b0;
         underflow_out <= 1'b0;
         pipe_vld      <= '0;
         pipe_gen      <= '0;
         pipe_last     <= '0;
      end else begin
         state         <= state_d;
         wr_idx        <= wr_idx_d;
         rd_idx        <= rd_idx_d;
         gen           <= gen_d;
         underflow_out <= underflow_d;
         pipe_vld      <= {pipe_vld[LAT-2:0], issue};
         pipe_gen      <= {pipe_gen[LAT-2:0], gen};
         pipe_last     <= {pipe_last[LAT-2:0], (rd_idx == LAST_IDX)};
      end
   end

   montgomery_bram_sdp #(
      .WIDTH (REGISTER_SIZE),
      .DEPTH (NUM_BLOCKS),
      .AW    (IDX_W)
   ) u_mem (
      .clk_in (clk_in),
      .we     (mem_we),
      .waddr  (wr_idx),
      .wdata  (load_block_in),
      .re     (issue),
      .raddr  (rd_idx),
      .rdata  (mem_rdata)
   );

   constant_prefetch_fifo #(
      .WIDTH (REGISTER_SIZE)
   ) u_fifo (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .push      (ret_push),
      .push_data (mem_rdata),
      .push_last (pipe_last[LAT-1]),
      .pop       (pop),
      .flush     (flush),
      .head_data (head_data),
      .head_last (head_last),
      .occupancy (occupancy)
   );

   assign load_ready_out  = (state == ST_LOAD);
   assign block_valid_out = fifo_valid;
   assign block_out       = fifo_valid ? head_data : '0;
   assign last_block_out  = fifo_valid & head_last;

endmodule

// File: tb/tb_montgomery_constant_server.sv
// Directed bench for montgomery_constant_server: streaming, gaps, rewind,
// underflow, async reset and reload while serving.
module tb_montgomery_constant_server;

   localparam int unsigned RS = 32;
   localparam int unsigned NB = 128;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b1;
   logic          load_start_in = 1'b0;
   logic          load_valid_in = 1'b0;
   logic [RS-1:0] load_block_in = '0;
   logic          load_ready_out;
   logic          rewind_in = 1'b0;
   logic          consumed_in = 1'b0;
   logic [RS-1:0] block_out;
   logic          block_valid_out;
   logic          last_block_out;
   logic          underflow_out;

   int checks   = 0;
   int failures = 0;

   montgomery_constant_server #(.REGISTER_SIZE(RS), .NUM_BLOCKS(NB)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .load_start_in   (load_start_in),
      .load_valid_in   (load_valid_in),
      .load_block_in   (load_block_in),
      .load_ready_out  (load_ready_out),
      .rewind_in       (rewind_in),
      .consumed_in     (consumed_in),
      .block_out       (block_out),
      .block_valid_out (block_valid_out),
      .last_block_out  (last_block_out),
      .underflow_out   (underflow_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // Loads base+i into block i; returns in cycle L+1 (first SERVE cycle).
   task automatic load_const(input logic [RS-1:0] base, input bit do_start);
      if (do_start) begin
         load_start_in = 1'b1;
         step();
         load_start_in = 1'b0;
      end
      for (int i = 0; i < int'(NB); i++) begin
         load_valid_in = 1'b1;
         load_block_in = base + RS'(i);
         step();
      end
      load_valid_in = 1'b0;
      load_block_in = '0;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (block_out !== '0 || block_valid_out !== 1'b0 || last_block_out !== 1'b0 ||
          underflow_out !== 1'b0 || load_ready_out !== 1'b1) begin
         failures++;
         $display("FAIL reset_values: got blk=%h v=%b last=%b uf=%b rdy=%b want 0/0/0/0/1",
                  block_out, block_valid_out, last_block_out, underflow_out, load_ready_out);
      end
      step();
      rst_in = 1'b0;
      step();
   endtask

   task automatic test_stream();
      logic [RS-1:0] exp;
      load_const(32'd1, 1'b1);
      checks++;
      if (load_ready_out !== 1'b0) begin
         failures++;
         $display("FAIL serve_ready: got %b want 0", load_ready_out);
      end
      for (int c = 1; c <= 3; c++) begin
         checks++;
         if (block_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL first_latency L+%0d: valid=%b want 0", c, block_valid_out);
         end
         step();
      end
      for (int n = 0; n < 300; n++) begin
         exp = RS'(n % NB) + 32'd1;
         checks++;
         if (block_valid_out !== 1'b1 || block_out !== exp || last_block_out !== (exp == 32'd128)) begin
            failures++;
            $display("FAIL stream n=%0d: got v=%b blk=%0d last=%b want v=1 blk=%0d last=%b",
                     n, block_valid_out, block_out, last_block_out, exp, (exp == 32'd128));
         end
         consumed_in = 1'b1;
         step();
      end
      consumed_in = 1'b0;
      checks++;
      if (underflow_out !== 1'b0) begin
         failures++;
         $display("FAIL stream_underflow: got %b want 0", underflow_out);
      end
   endtask

   task automatic test_random_gaps();
      logic [RS-1:0] exp;
      int duty;
      int taken;
      exp   = 32'd1;
      taken = 0;
      load_const(32'd1, 1'b1);
      for (int n = 0; n < 600; n++) begin
         duty = 10 + 10 * ((n / 100) % 6);
         consumed_in = 1'b0;
         if (block_valid_out && ($urandom_range(0, 99) < duty)) begin
            checks++;
            if (block_out !== exp || last_block_out !== (exp == 32'd128)) begin
               failures++;
               $display("FAIL gaps #%0d: got blk=%0d last=%b want blk=%0d last=%b",
                        taken, block_out, last_block_out, exp, (exp == 32'd128));
            end
            consumed_in = 1'b1;
            exp = (exp == 32'd128) ? 32'd1 : exp + 32'd1;
            taken++;
         end
         step();
      end
      consumed_in = 1'b0;
      checks++;
      if (taken < 40 || underflow_out !== 1'b0) begin
         failures++;
         $display("FAIL gaps_summary: taken=%0d uf=%b want >=40 and 0", taken, underflow_out);
      end
   endtask

   task automatic test_rewind();
      load_const(32'd1, 1'b1);
      step(); step(); step();
      for (int n = 0; n < 10; n++) begin
         consumed_in = 1'b1;
         step();
      end
      consumed_in = 1'b0;
      checks++;
      if (block_valid_out !== 1'b1 || block_out !== 32'd11) begin
         failures++;
         $display("FAIL pre_rewind: got v=%b blk=%0d want 1/11", block_valid_out, block_out);
      end
      rewind_in   = 1'b1;
      consumed_in = 1'b1;
      step();
      rewind_in   = 1'b0;
      consumed_in = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         checks++;
         if (block_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL rewind W+%0d: valid=%b want 0", c, block_valid_out);
         end
         step();
      end
      checks++;
      if (block_valid_out !== 1'b1 || block_out !== 32'd1 || underflow_out !== 1'b0) begin
         failures++;
         $display("FAIL rewind W+4: got v=%b blk=%0d uf=%b want 1/1/0",
                  block_valid_out, block_out, underflow_out);
      end
      consumed_in = 1'b1;
      step();
      consumed_in = 1'b0;
      checks++;
      if (block_out !== 32'd2) begin
         failures++;
         $display("FAIL rewind_next: got blk=%0d want 2", block_out);
      end
   endtask

   task automatic test_underflow();
      load_const(32'd1, 1'b1);
      consumed_in = 1'b1;
      step();
      consumed_in = 1'b0;
      checks++;
      if (underflow_out !== 1'b1) begin
         failures++;
         $display("FAIL underflow_set: got %b want 1", underflow_out);
      end
      step(); step();
      checks++;
      if (underflow_out !== 1'b1 || block_valid_out !== 1'b1 || block_out !== 32'd1) begin
         failures++;
         $display("FAIL underflow_sticky: got uf=%b v=%b blk=%0d want 1/1/1",
                  underflow_out, block_valid_out, block_out);
      end
      load_start_in = 1'b1;
      step();
      load_start_in = 1'b0;
      checks++;
      if (underflow_out !== 1'b0 || block_valid_out !== 1'b0 || load_ready_out !== 1'b1) begin
         failures++;
         $display("FAIL underflow_clear: got uf=%b v=%b rdy=%b want 0/0/1",
                  underflow_out, block_valid_out, load_ready_out);
      end
   endtask

   task automatic test_async_reset();
      logic [RS-1:0] exp;
      load_const(32'd1, 1'b1);
      step(); step(); step();
      consumed_in = 1'b1;
      step(); step();
      consumed_in = 1'b0;
      #3 rst_in = 1'b1;
      #1;
      checks++;
      if (block_out !== '0 || block_valid_out !== 1'b0 || last_block_out !== 1'b0 ||
          underflow_out !== 1'b0 || load_ready_out !== 1'b1) begin
         failures++;
         $display("FAIL async_reset: got blk=%h v=%b last=%b uf=%b rdy=%b want 0/0/0/0/1",
                  block_out, block_valid_out, last_block_out, underflow_out, load_ready_out);
      end
      step();
      rst_in = 1'b0;
      step();
      load_const(32'hA5A5_0000, 1'b1);
      step(); step(); step();
      for (int n = 0; n < 130; n++) begin
         exp = 32'hA5A5_0000 + RS'(n % NB);
         checks++;
         if (block_valid_out !== 1'b1 || block_out !== exp || last_block_out !== ((n % NB) == 127)) begin
            failures++;
            $display("FAIL reload n=%0d: got v=%b blk=%h last=%b want 1/%h/%b",
                     n, block_valid_out, block_out, last_block_out, exp, ((n % NB) == 127));
         end
         consumed_in = 1'b1;
         step();
      end
      consumed_in = 1'b0;
   endtask

   task automatic test_load_start_midserve();
      logic [RS-1:0] exp;
      load_const(32'd1, 1'b1);
      step(); step(); step();
      for (int n = 0; n < 5; n++) begin
         consumed_in = 1'b1;
         step();
      end
      load_start_in = 1'b1;
      step();
      load_start_in = 1'b0;
      consumed_in   = 1'b0;
      checks++;
      if (block_valid_out !== 1'b0 || load_ready_out !== 1'b1) begin
         failures++;
         $display("FAIL midserve_flush: got v=%b rdy=%b want 0/1", block_valid_out, load_ready_out);
      end
      step();
      checks++;
      if (block_valid_out !== 1'b0) begin
         failures++;
         $display("FAIL midserve_stale: valid=%b want 0", block_valid_out);
      end
      load_const(32'd1000, 1'b0);
      step(); step(); step();
      for (int n = 0; n < 20; n++) begin
         exp = 32'd1000 + RS'(n);
         checks++;
         if (block_valid_out !== 1'b1 || block_out !== exp) begin
            failures++;
            $display("FAIL midserve_stream n=%0d: got v=%b blk=%0d want 1/%0d",
                     n, block_valid_out, block_out, exp);
         end
         consumed_in = 1'b1;
         step();
      end
      consumed_in = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_random_gaps();
      test_rewind();
      test_underflow();
      test_async_reset();
      test_load_start_midserve();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
